stopwatch_bcd: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 67 ++++++
 rtl/btn_conditioner.sv | 61 ++++++
 rtl/stopwatch_bcd.sv | 140 ++++++++++++++
 tb/tb_stopwatch_bcd.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch: FSM states, time record,
// BCD limits and the cascaded BCD increment.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  // Field order matches the display, most significant digit first.
  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
    logic [3:0] c10;
    logic [3:0] c1;
  } sw_time_t;

  localparam sw_time_t TIME_MAX = 24'h595999;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

  function automatic sw_time_t bcd_inc(input sw_time_t t);
    sw_time_t n;
    n = t;
    if (t.c1 != BCD_NINE) n.c1 = t.c1 + 4'd1;
    else begin
      n.c1 = 4'd0;
      if (t.c10 != BCD_NINE) n.c10 = t.c10 + 4'd1;
      else begin
        n.c10 = 4'd0;
        if (t.s1 != BCD_NINE) n.s1 = t.s1 + 4'd1;
        else begin
          n.s1 = 4'd0;
          if (t.s10 != BCD_FIVE) n.s10 = t.s10 + 4'd1;
          else begin
            n.s10 = 4'd0;
            if (t.m1 != BCD_NINE) n.m1 = t.m1 + 4'd1;
            else begin
              n.m1 = 4'd0;
              n.m10 = (t.m10 != BCD_FIVE) ? t.m10 + 4'd1 : 4'd0;
            end
          end
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and a
// one-cycle pulse on each accepted press (release is silent).
import stopwatch_pkg::*;

module btn_conditioner #(
  parameter int DEBOUNCE = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = clog2(DEBOUNCE + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          prev_q, prev_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips only after DEBOUNCE consecutive disagreeing samples.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    prev_d  = level_q;
    press_d = level_q & ~prev_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// mm:ss.cc stopwatch driving six BCD digits for the 7-segment decoders,
// with start/stop and lap/clear push-buttons.
import stopwatch_pkg::*;

module stopwatch_bcd #(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 100,
  parameter int DEBOUNCE = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lc,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] digit5,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = clog2(DIV);

  sw_state_e     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  sw_time_t      time_q, time_d;
  sw_time_t      lap_q, lap_d;
  sw_time_t      digits_q, digits_d;
  logic          running_q, running_d;
  logic          lap_active_q, lap_active_d;
  logic          wrap_q, wrap_d;

  logic ss_press, lc_press;
  logic counting, tick, clear, capture;

  btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_ss (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_ss),
    .press (ss_press)
  );

  btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_lc (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_lc),
    .press (lc_press)
  );

  // Start/stop always wins over a lap/clear press in the same cycle.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_press) state_d = RUN;
      end
      RUN: begin
        if (ss_press) state_d = PAUSE;
        else if (lc_press) begin
          state_d = LAP;
          capture = 1'b1;
        end
      end
      LAP: begin
        if (ss_press) state_d = PAUSE;
        else if (lc_press) state_d = RUN;
      end
      PAUSE: begin
        if (ss_press) state_d = RUN;
        else if (lc_press) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc_q == PW'(DIV - 1));

  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    wrap_d  = 1'b0;
    if (clear) begin
      presc_d = '0;
      time_d  = '0;
    end else if (tick) begin
      presc_d = '0;
      time_d  = bcd_inc(time_q);
      wrap_d  = (time_q == TIME_MAX);
    end else if (counting) begin
      presc_d = presc_q + 1'b1;
    end
    lap_d        = capture ? time_q : lap_q;
    digits_d     = (state_d == LAP) ? lap_d : time_q;
    running_d    = (state_d == RUN) || (state_d == LAP);
    lap_active_d = (state_d == LAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      time_q       <= '0;
      lap_q        <= '0;
      digits_q     <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      time_q       <= time_d;
      lap_q        <= lap_d;
      digits_q     <= digits_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      wrap_q       <= wrap_d;
    end
  end

  assign digit0     = digits_q.c1;
  assign digit1     = digits_q.c10;
  assign digit2     = digits_q.s1;
  assign digit3     = digits_q.s10;
  assign digit4     = digits_q.m1;
  assign digit5     = digits_q.m10;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with DIV=10 and DEBOUNCE=4; a clean press
// reaches the FSM 8 edges after the input rises, so R = rise edge + 8.
import stopwatch_pkg::*;

module tb_stopwatch_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lc = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5;
  logic       running, lap_active, wrap;
  logic [23:0] shown;

  int tests = 0;
  int errors = 0;

  assign shown = {digit5, digit4, digit3, digit2, digit1, digit0};

  stopwatch_bcd #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_ss     (btn_ss),
    .btn_lc     (btn_lc),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .digit4     (digit4),
    .digit5     (digit5),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the chosen buttons now and release them 10 edges later.
  task automatic press(input logic ss, input logic lc);
    if (ss) btn_ss = 1'b1;
    if (lc) btn_lc = 1'b1;
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        btn_ss = 1'b0;
        btn_lc = 1'b0;
      end
    join_none
  endtask

  task automatic do_reset();
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    rst = 1'b1;
    cyc(12);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (shown !== 24'h0 || running !== 1'b0 || lap_active !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: digits=%h run=%b lap=%b wrap=%b, want 000000 0 0 0", shown, running, lap_active, wrap);
    end
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      tests++;
      if (shown !== 24'h0 || running !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_quiet cycle %0d: digits=%h run=%b wrap=%b, want 000000 0 0", i, shown, running, wrap);
      end
    end
  endtask

  task automatic test_start();
    do_reset();
    press(1'b1, 1'b0);
    cyc(7);
    tests++;
    if (running !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_early: running=%b, want 0", running);
    end
    cyc(1);
    tests++;
    if (running !== 1'b1 || lap_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_run: running=%b lap=%b, want 1 0", running, lap_active);
    end
    cyc(100);
    tests++;
    if (shown !== 24'h000009) begin
      errors++;
      $display("[TB] FAIL start_latency: digits=%h, want 000009", shown);
    end
    cyc(1);
    tests++;
    if (shown !== 24'h000010 || running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_10ticks: digits=%h run=%b, want 000010 1", shown, running);
    end
  endtask

  task automatic test_glitch_and_priority();
    do_reset();
    btn_ss = 1'b1;
    cyc(3);
    btn_ss = 1'b0;
    cyc(20);
    tests++;
    if (running !== 1'b0 || shown !== 24'h0) begin
      errors++;
      $display("[TB] FAIL glitch: running=%b digits=%h, want 0 000000", running, shown);
    end
    press(1'b1, 1'b0);
    cyc(8);
    cyc(30);
    press(1'b1, 1'b1);
    cyc(7);
    tests++;
    if (running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL both_early: running=%b, want 1", running);
    end
    cyc(1);
    tests++;
    if (running !== 1'b0 || lap_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL both_pause: running=%b lap=%b, want 0 0", running, lap_active);
    end
    cyc(10);
    tests++;
    if (shown !== 24'h000003) begin
      errors++;
      $display("[TB] FAIL both_no_clear: digits=%h, want 000003", shown);
    end
    tests++;
    if (dut.lap_q !== 24'h0) begin
      errors++;
      $display("[TB] FAIL both_lap_untouched: lap=%h, want 000000", dut.lap_q);
    end
  endtask

  task automatic test_lap();
    do_reset();
    press(1'b1, 1'b0);
    cyc(8);
    cyc(367);
    press(1'b0, 1'b1);
    cyc(7);
    tests++;
    if (lap_active !== 1'b0 || shown !== 24'h000037) begin
      errors++;
      $display("[TB] FAIL lap_before: lap=%b digits=%h, want 0 000037", lap_active, shown);
    end
    cyc(1);
    tests++;
    if (lap_active !== 1'b1 || running !== 1'b1 || shown !== 24'h000037) begin
      errors++;
      $display("[TB] FAIL lap_enter: lap=%b run=%b digits=%h, want 1 1 000037", lap_active, running, shown);
    end
    cyc(100);
    tests++;
    if (shown !== 24'h000037) begin
      errors++;
      $display("[TB] FAIL lap_frozen: digits=%h, want 000037", shown);
    end
    cyc(392);
    press(1'b0, 1'b1);
    cyc(7);
    tests++;
    if (lap_active !== 1'b1 || shown !== 24'h000037) begin
      errors++;
      $display("[TB] FAIL lap_hold: lap=%b digits=%h, want 1 000037", lap_active, shown);
    end
    cyc(1);
    tests++;
    if (lap_active !== 1'b0 || running !== 1'b1 || shown !== 24'h000087) begin
      errors++;
      $display("[TB] FAIL lap_leave: lap=%b run=%b digits=%h, want 0 1 000087", lap_active, running, shown);
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    press(1'b1, 1'b0);
    cyc(8);
    cyc(8);
    press(1'b1, 1'b0);
    cyc(8);
    tests++;
    if (running !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_enter: running=%b, want 0", running);
    end
    cyc(14);
    tests++;
    if (shown !== 24'h000001) begin
      errors++;
      $display("[TB] FAIL pause_hold: digits=%h, want 000001", shown);
    end
    press(1'b1, 1'b0);
    cyc(8);
    tests++;
    if (running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resume: running=%b, want 1", running);
    end
    cyc(4);
    tests++;
    if (shown !== 24'h000001) begin
      errors++;
      $display("[TB] FAIL resume_partial_early: digits=%h, want 000001", shown);
    end
    cyc(1);
    tests++;
    if (shown !== 24'h000002) begin
      errors++;
      $display("[TB] FAIL resume_partial_tick: digits=%h, want 000002", shown);
    end
    cyc(7);
    press(1'b1, 1'b0);
    cyc(8);
    tests++;
    if (running !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause2: running=%b, want 0", running);
    end
    cyc(12);
    tests++;
    if (shown !== 24'h000003) begin
      errors++;
      $display("[TB] FAIL pause2_value: digits=%h, want 000003", shown);
    end
    press(1'b0, 1'b1);
    cyc(9);
    tests++;
    if (shown !== 24'h0 || running !== 1'b0 || lap_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear: digits=%h run=%b lap=%b, want 000000 0 0", shown, running, lap_active);
    end
    tests++;
    if (dut.presc_q !== 4'd0 || dut.state_q !== IDLE) begin
      errors++;
      $display("[TB] FAIL clear_internal: presc=%0d state=%0d, want 0 0", dut.presc_q, dut.state_q);
    end
    cyc(20);
    tests++;
    if (shown !== 24'h0) begin
      errors++;
      $display("[TB] FAIL clear_idle: digits=%h, want 000000", shown);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    press(1'b1, 1'b0);
    cyc(8);
    cyc(1);
    dut.time_q = 24'h595998;
    cyc(10);
    tests++;
    if (shown !== 24'h595999) begin
      errors++;
      $display("[TB] FAIL wrap_max: digits=%h, want 595999", shown);
    end
    cyc(8);
    tests++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_early: wrap=%b, want 0", wrap);
    end
    cyc(1);
    tests++;
    if (wrap !== 1'b1 || shown !== 24'h595999) begin
      errors++;
      $display("[TB] FAIL wrap_pulse: wrap=%b digits=%h, want 1 595999", wrap, shown);
    end
    cyc(1);
    tests++;
    if (wrap !== 1'b0 || shown !== 24'h0) begin
      errors++;
      $display("[TB] FAIL wrap_after: wrap=%b digits=%h, want 0 000000", wrap, shown);
    end
    cyc(10);
    tests++;
    if (shown !== 24'h000001 || running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_continue: digits=%h run=%b, want 000001 1", shown, running);
    end
    cyc(4);
    rst = 1'b1;
    cyc(1);
    tests++;
    if (shown !== 24'h0 || running !== 1'b0 || lap_active !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: digits=%h run=%b lap=%b wrap=%b, want 000000 0 0 0", shown, running, lap_active, wrap);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_glitch_and_priority();
    test_lap();
    test_pause_resume();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
